// File: rtl/cursor_ctrl_if.sv
// Relative-move channel from the mouse packet decoder into cursor_ctrl.
// The master drives signed deltas with valid; the slave answers with ready.
interface cursor_ctrl_if #(
  parameter int DW = 9
);
  logic [DW-1:0] dx;
  logic [DW-1:0] dy;
  logic          mv_valid;
  logic          mv_ready;

  modport master (output dx, output dy, output mv_valid, input mv_ready);
  modport slave  (input dx, input dy, input mv_valid, output mv_ready);
endinterface

// File: rtl/cursor_ctrl.sv
// Cursor position sequencer: accumulates clamped relative moves into a working
// position and publishes it to the video generator once per frame at vsync fall.
module cursor_ctrl #(
  parameter logic [9:0] XMAX  = 10'd639,
  parameter logic [9:0] YMAX  = 10'd479,
  parameter logic [9:0] XINIT = 10'd320,
  parameter logic [9:0] YINIT = 10'd240,
  parameter int         DW    = 9
) (
  input  logic            vgaclk,
  input  logic            reset_b,
  cursor_ctrl_if.slave    mv,
  input  logic            recenter,
  input  logic            vsync,
  output logic [9:0]      xpt,
  output logic [9:0]      ypt,
  output logic            frame_upd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUM   = 2'd1,
    CLAMP = 2'd2
  } state_t;

  state_t               state_r;
  logic [9:0]           wx_r;
  logic [9:0]           wy_r;
  logic [DW-1:0]        dx_r;
  logic [DW-1:0]        dy_r;
  logic signed [11:0]   sx_r;
  logic signed [11:0]   sy_r;
  logic                 dirty_r;
  logic                 edge_pend_r;
  logic                 vsync_q_r;
  logic                 recenter_pend_r;

  logic signed [11:0]   dx_ext_s;
  logic signed [11:0]   dy_ext_s;
  logic [9:0]           cx_s;
  logic [9:0]           cy_s;
  logic                 fall_s;
  logic                 commit_s;
  logic                 rc_s;
  logic                 ready_s;

  assign dx_ext_s = {{(12-DW){dx_r[DW-1]}}, dx_r};
  assign dy_ext_s = {{(12-DW){dy_r[DW-1]}}, dy_r};

  assign fall_s   = vsync_q_r & ~vsync;
  assign commit_s = (state_r == IDLE) & edge_pend_r;
  // A recenter seen this cycle or parked during a move both block the handshake.
  assign rc_s     = recenter | recenter_pend_r;
  assign ready_s  = reset_b & (state_r == IDLE) & ~commit_s & ~rc_s;

  assign mv.mv_ready = ready_s;

  // Clamp the signed x sum into the visible range.
  always_comb begin
    cx_s = sx_r[9:0];
    if (sx_r < 12'sd0) begin
      cx_s = 10'd0;
    end else if (sx_r > $signed({2'b00, XMAX})) begin
      cx_s = XMAX;
    end else begin
      cx_s = sx_r[9:0];
    end
  end

  // Clamp the signed y sum into the visible range.
  always_comb begin
    cy_s = sy_r[9:0];
    if (sy_r < 12'sd0) begin
      cy_s = 10'd0;
    end else if (sy_r > $signed({2'b00, YMAX})) begin
      cy_s = YMAX;
    end else begin
      cy_s = sy_r[9:0];
    end
  end

  // Move FSM, vsync edge tracking and per-frame commit of the working position.
  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b) begin
      state_r         <= IDLE;
      wx_r            <= XINIT;
      wy_r            <= YINIT;
      xpt             <= XINIT;
      ypt             <= YINIT;
      dx_r            <= '0;
      dy_r            <= '0;
      sx_r            <= 12'sd0;
      sy_r            <= 12'sd0;
      dirty_r         <= 1'b0;
      edge_pend_r     <= 1'b0;
      vsync_q_r       <= 1'b1;
      recenter_pend_r <= 1'b0;
      frame_upd       <= 1'b0;
    end else begin
      vsync_q_r   <= vsync;
      frame_upd   <= 1'b0;
      // A fresh fall on the commit edge must survive as a new pending commit.
      edge_pend_r <= fall_s | (edge_pend_r & ~commit_s);
      case (state_r)
        IDLE: begin
          if (commit_s) begin
            if (dirty_r) begin
              xpt       <= wx_r;
              ypt       <= wy_r;
              frame_upd <= 1'b1;
              dirty_r   <= 1'b0;
            end
            if (recenter) begin
              recenter_pend_r <= 1'b1;
            end
          end else if (rc_s) begin
            wx_r            <= XINIT;
            wy_r            <= YINIT;
            dirty_r         <= 1'b1;
            recenter_pend_r <= 1'b0;
          end else if (mv.mv_valid) begin
            dx_r    <= mv.dx;
            dy_r    <= mv.dy;
            state_r <= SUM;
          end
        end
        SUM: begin
          // Screen y grows downward, so an upward move subtracts.
          sx_r    <= $signed({2'b00, wx_r}) + dx_ext_s;
          sy_r    <= $signed({2'b00, wy_r}) - dy_ext_s;
          state_r <= CLAMP;
          if (recenter) begin
            recenter_pend_r <= 1'b1;
          end
        end
        CLAMP: begin
          wx_r    <= cx_s;
          wy_r    <= cy_s;
          dirty_r <= 1'b1;
          state_r <= IDLE;
          if (recenter) begin
            recenter_pend_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Randomised and directed bench for cursor_ctrl with a queue-based scoreboard
// fed by an arithmetic position model and drained by an output monitor.
module tb_cursor_ctrl;

  logic       vgaclk;
  logic       reset_b;
  logic       recenter;
  logic       vsync;
  logic [9:0] xpt;
  logic [9:0] ypt;
  logic       frame_upd;

  cursor_ctrl_if mv_if ();

  cursor_ctrl dut (
    .vgaclk    (vgaclk),
    .reset_b   (reset_b),
    .mv        (mv_if),
    .recenter  (recenter),
    .vsync     (vsync),
    .xpt       (xpt),
    .ypt       (ypt),
    .frame_upd (frame_upd)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [19:0] exp_q[$];
  int          mwx, mwy, cx, cy;
  bit          mdirty;
  bit          upd_prev;

  initial vgaclk = 1'b0;
  always #20 vgaclk = ~vgaclk;

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every frame_upd pulse must match the oldest expected commit.
  always @(negedge vgaclk) begin
    if (reset_b) begin
      if (frame_upd) begin
        check("upd_single_cycle", int'(upd_prev), 0);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_upd: got x=%0d y=%0d, expected no update", xpt, ypt);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          if (xpt !== e[19:10] || ypt !== e[9:0]) begin
            n_err++;
            $display("FAIL commit_xy: got x=%0d y=%0d, expected x=%0d y=%0d",
                     xpt, ypt, e[19:10], e[9:0]);
          end
        end
      end
      upd_prev = frame_upd;
    end else begin
      upd_prev = 1'b0;
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge vgaclk); #1;
    while (!mv_if.mv_ready && t < 20) begin
      @(negedge vgaclk); #1;
      t++;
    end
    check("ready_timeout", int'(mv_if.mv_ready), 1);
  endtask

  task automatic model_move(input int dxv, input int dyv);
    mwx    = clampi(mwx + dxv, 639);
    mwy    = clampi(mwy - dyv, 479);
    mdirty = 1'b1;
  endtask

  task automatic push_commit();
    if (mdirty) begin
      exp_q.push_back({mwx[9:0], mwy[9:0]});
      cx = mwx;
      cy = mwy;
    end
    mdirty = 1'b0;
  endtask

  task automatic send_move(input int dxv, input int dyv);
    int t;
    t = 0;
    @(negedge vgaclk);
    mv_if.dx = dxv[8:0];
    mv_if.dy = dyv[8:0];
    mv_if.mv_valid = 1'b1;
    #1;
    while (!mv_if.mv_ready && t < 20) begin
      @(negedge vgaclk); #1;
      t++;
    end
    if (!mv_if.mv_ready) begin
      check("move_timeout", 0, 1);
      mv_if.mv_valid = 1'b0;
    end else begin
      @(posedge vgaclk); #1;
      mv_if.mv_valid = 1'b0;
      model_move(dxv, dyv);
    end
  endtask

  task automatic recenter_idle();
    wait_ready();
    recenter = 1'b1;
    @(posedge vgaclk); #1;
    recenter = 1'b0;
    mwx = 320; mwy = 240; mdirty = 1'b1;
  endtask

  // One vsync fall from IDLE: commit lands two edges after vsync is sampled low.
  task automatic frame();
    bit e;
    wait_ready();
    vsync = 1'b0;
    e = mdirty;
    push_commit();
    @(negedge vgaclk);
    check("upd_early", int'(frame_upd), 0);
    @(negedge vgaclk);
    check("upd_latency", int'(frame_upd), int'(e));
    @(negedge vgaclk);
    check("upd_width", int'(frame_upd), 0);
    vsync = 1'b1;
    check("x_hold", int'(xpt), cx);
    check("y_hold", int'(ypt), cy);
    repeat (2) @(negedge vgaclk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_b = 1'b0; recenter = 1'b0; vsync = 1'b1;
    mv_if.dx = '0; mv_if.dy = '0; mv_if.mv_valid = 1'b0;
    mwx = 320; mwy = 240; cx = 320; cy = 240; mdirty = 1'b0;
    repeat (3) @(negedge vgaclk);
    check("rst_ready", int'(mv_if.mv_ready), 0);
    check("rst_x", int'(xpt), 320);
    check("rst_y", int'(ypt), 240);
    check("rst_upd", int'(frame_upd), 0);
    reset_b = 1'b1; #1;
    check("ready_after_rst", int'(mv_if.mv_ready), 1);

    // No moves: two vsync falls must not produce an update.
    frame();
    frame();

    // Accumulation within one frame.
    send_move(5, 3);
    send_move(-2, 0);
    wait_ready();
    check("x_before_fall", int'(xpt), 320);
    frame();
    check("acc_x", int'(xpt), 323);
    check("acc_y", int'(ypt), 237);

    // Clamping at every edge of the screen.
    recenter_idle(); frame();
    send_move(255, 0); frame(); check("clamp_x575", int'(xpt), 575);
    send_move(255, 0); frame(); check("clamp_xmax", int'(xpt), 639);
    for (int i = 0; i < 3; i++) send_move(-256, 0);
    frame(); check("clamp_x0", int'(xpt), 0);
    for (int i = 0; i < 2; i++) send_move(0, 255);
    frame(); check("clamp_y0", int'(ypt), 0);
    for (int i = 0; i < 3; i++) send_move(0, -256);
    frame(); check("clamp_ymax", int'(ypt), 479);

    // Move accepted one cycle before the fall; held valid consumed once.
    wait_ready();
    mv_if.dx = 9'd20; mv_if.dy = 9'h1FC; mv_if.mv_valid = 1'b1;
    @(posedge vgaclk);
    model_move(20, -4);
    @(negedge vgaclk);
    vsync = 1'b0;
    push_commit();
    check("defer_ready_sum", int'(mv_if.mv_ready), 0);
    @(negedge vgaclk);
    check("defer_ready_clamp", int'(mv_if.mv_ready), 0);
    @(negedge vgaclk);
    check("defer_ready_commit", int'(mv_if.mv_ready), 0);
    check("defer_no_upd_yet", int'(frame_upd), 0);
    @(negedge vgaclk);
    check("defer_upd", int'(frame_upd), 1);
    check("defer_x", int'(xpt), 20);
    check("defer_y", int'(ypt), 479);
    mv_if.mv_valid = 1'b0;
    vsync = 1'b1;
    frame();

    // Recenter pulse during SUM, with a move waiting behind it.
    recenter_idle(); frame();
    send_move(-220, 0); frame(); check("pre_rc_x", int'(xpt), 100);
    wait_ready();
    mv_if.dx = 9'd10; mv_if.dy = 9'd0; mv_if.mv_valid = 1'b1;
    @(posedge vgaclk); #1;
    mv_if.mv_valid = 1'b0;
    @(negedge vgaclk);
    recenter = 1'b1;
    check("rc_ready_sum", int'(mv_if.mv_ready), 0);
    @(negedge vgaclk);
    recenter = 1'b0;
    mv_if.dx = 9'd7; mv_if.mv_valid = 1'b1;
    check("rc_ready_clamp", int'(mv_if.mv_ready), 0);
    @(negedge vgaclk);
    check("rc_ready_pend", int'(mv_if.mv_ready), 0);
    vsync = 1'b0;
    mwx = 320; mwy = 240; mdirty = 1'b1;
    push_commit();
    @(negedge vgaclk);
    check("rc_ready_commit", int'(mv_if.mv_ready), 0);
    @(negedge vgaclk);
    check("rc_upd", int'(frame_upd), 1);
    check("rc_x", int'(xpt), 320);
    check("rc_y", int'(ypt), 240);
    check("rc_ready_back", int'(mv_if.mv_ready), 1);
    vsync = 1'b1;
    @(posedge vgaclk); #1;
    mv_if.mv_valid = 1'b0;
    model_move(7, 0);
    frame(); check("rc_then_move_x", int'(xpt), 327);

    // Async reset mid-SUM with dirty and a pending commit.
    send_move(3, 3);
    wait_ready();
    mv_if.dx = 9'd1; mv_if.dy = 9'd1; mv_if.mv_valid = 1'b1; vsync = 1'b0;
    @(posedge vgaclk); #5;
    reset_b = 1'b0; #1;
    check("arst_x", int'(xpt), 320);
    check("arst_y", int'(ypt), 240);
    check("arst_upd", int'(frame_upd), 0);
    check("arst_ready", int'(mv_if.mv_ready), 0);
    mv_if.mv_valid = 1'b0; vsync = 1'b1;
    exp_q.delete();
    mwx = 320; mwy = 240; cx = 320; cy = 240; mdirty = 1'b0;
    repeat (2) @(negedge vgaclk);
    reset_b = 1'b1;
    frame();
    send_move(-10, 10); frame();

    // Randomised frames against the model.
    for (int f = 0; f < 12; f++) begin
      int nm;
      nm = int'($urandom_range(0, 4));
      if ($urandom_range(0, 4) == 0) recenter_idle();
      for (int m = 0; m < nm; m++) begin
        send_move(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256);
      end
      frame();
    end

    repeat (4) @(negedge vgaclk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
